// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: picks one trap event by fixed priority, saves the PC and
// cause, redirects fetch to the handler or back to mepc, and flushes the pipeline.
module trap_controller #(
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        resetActiveLow,
  input  logic        instructionValid,
  input  logic [31:0] pcCurrent,
  input  logic        illegalInstruction,
  input  logic        ecallDetected,
  input  logic        ebreakDetected,
  input  logic        mretDetected,
  input  logic        externalIrq,
  input  logic        timerIrq,
  input  logic [31:0] mepcValue,
  output logic        csrWriteEnable,
  output logic [31:0] mepcWriteValue,
  output logic [31:0] mcauseValue,
  output logic        pcRedirectValid,
  output logic [31:0] pcRedirectTarget,
  output logic        pipelineStall,
  output logic        pipelineFlush,
  output logic        inTrapHandler
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CAPTURE  = 3'd1,
    REDIRECT = 3'd2,
    FLUSH    = 3'd3,
    HANDLER  = 3'd4,
    RETURN   = 3'd5
  } state_t;

  localparam logic [31:0] CAUSE_EXTERNAL = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER    = 32'h8000_0007;
  localparam logic [31:0] CAUSE_ILLEGAL  = 32'd2;
  localparam logic [31:0] CAUSE_EBREAK   = 32'd3;
  localparam logic [31:0] CAUSE_ECALL    = 32'd11;
  localparam logic [3:0]  FLUSH_LOAD     = 4'(FLUSH_CYCLES - 1);

  state_t      state;
  state_t      stateNext;
  logic [3:0]  flushCount;
  logic        returnFlag;

  logic        sampling;
  logic        irqTaken;
  logic        exceptionTaken;
  logic        mretAsIllegal;
  logic        trapTaken;
  logic        mretTaken;
  logic [31:0] causeNext;

  // Interrupts are masked inside the handler, so the irq inputs only matter from IDLE.
  function automatic logic [31:0] selectCause(
    input logic irqEnable,
    input logic ext,
    input logic tmr,
    input logic ill,
    input logic ebrk,
    input logic ecall
  );
    logic [31:0] cause;
    cause = CAUSE_ILLEGAL;
    if (irqEnable && ext)      cause = CAUSE_EXTERNAL;
    else if (irqEnable && tmr) cause = CAUSE_TIMER;
    else if (ill)              cause = CAUSE_ILLEGAL;
    else if (ebrk)             cause = CAUSE_EBREAK;
    else if (ecall)            cause = CAUSE_ECALL;
    return cause;
  endfunction

  always_comb begin
    sampling       = instructionValid && ((state == IDLE) || (state == HANDLER));
    irqTaken       = sampling && (state == IDLE) && (externalIrq || timerIrq);
    exceptionTaken = sampling && (illegalInstruction || ecallDetected || ebreakDetected);
    mretAsIllegal  = sampling && (state == IDLE) && mretDetected;
    trapTaken      = irqTaken || exceptionTaken || mretAsIllegal;
    mretTaken      = sampling && (state == HANDLER) && mretDetected && !exceptionTaken;
    causeNext      = selectCause(state == IDLE, externalIrq, timerIrq,
                                 illegalInstruction, ebreakDetected, ecallDetected);
  end

  always_ff @(posedge clock or negedge resetActiveLow) begin
    if (!resetActiveLow) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (trapTaken) stateNext = CAPTURE;
      end
      CAPTURE:  stateNext = REDIRECT;
      REDIRECT: stateNext = FLUSH;
      FLUSH: begin
        if (flushCount == 4'd0) stateNext = returnFlag ? IDLE : HANDLER;
      end
      HANDLER: begin
        if (trapTaken)      stateNext = CAPTURE;
        else if (mretTaken) stateNext = RETURN;
      end
      RETURN:   stateNext = FLUSH;
      default:  stateNext = IDLE;
    endcase
  end

  // Flush length counter and the trap/return marker that decides where FLUSH exits to.
  always_ff @(posedge clock or negedge resetActiveLow) begin
    if (!resetActiveLow) begin
      flushCount <= 4'd0;
      returnFlag <= 1'b0;
    end else begin
      if ((state == REDIRECT) || (state == RETURN)) begin
        flushCount <= FLUSH_LOAD;
      end else if ((state == FLUSH) && (flushCount != 4'd0)) begin
        flushCount <= flushCount - 4'd1;
      end
      if (state == REDIRECT) begin
        returnFlag <= 1'b0;
      end else if (state == RETURN) begin
        returnFlag <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetActiveLow) begin
    if (!resetActiveLow) begin
      mepcWriteValue <= 32'd0;
      mcauseValue    <= 32'd0;
    end else if (trapTaken) begin
      mepcWriteValue <= pcCurrent;
      mcauseValue    <= causeNext;
    end
  end

  always_comb begin
    csrWriteEnable   = 1'b0;
    pcRedirectValid  = 1'b0;
    pcRedirectTarget = 32'd0;
    pipelineStall    = 1'b0;
    pipelineFlush    = 1'b0;
    inTrapHandler    = 1'b0;
    unique case (state)
      CAPTURE: begin
        csrWriteEnable = 1'b1;
        pipelineStall  = 1'b1;
      end
      REDIRECT: begin
        pcRedirectValid  = 1'b1;
        pcRedirectTarget = TRAP_VECTOR;
        pipelineFlush    = 1'b1;
        pipelineStall    = 1'b1;
      end
      FLUSH: begin
        pipelineFlush = 1'b1;
        inTrapHandler = !returnFlag;
      end
      HANDLER: begin
        inTrapHandler = 1'b1;
      end
      RETURN: begin
        pcRedirectValid  = 1'b1;
        pcRedirectTarget = mepcValue;
        pipelineFlush    = 1'b1;
        pipelineStall    = 1'b1;
        inTrapHandler    = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: a cycle-by-cycle vector table plus hand-written
// reset and priority sequences.
module tb_trap_controller;

  logic        clock = 1'b0;
  logic        resetActiveLow;
  logic        instructionValid;
  logic [31:0] pcCurrent;
  logic        illegalInstruction;
  logic        ecallDetected;
  logic        ebreakDetected;
  logic        mretDetected;
  logic        externalIrq;
  logic        timerIrq;
  logic [31:0] mepcValue;
  logic        csrWriteEnable;
  logic [31:0] mepcWriteValue;
  logic [31:0] mcauseValue;
  logic        pcRedirectValid;
  logic [31:0] pcRedirectTarget;
  logic        pipelineStall;
  logic        pipelineFlush;
  logic        inTrapHandler;

  int assertions = 0;
  int failures   = 0;

  trap_controller #(
    .TRAP_VECTOR (32'h0000_0100),
    .FLUSH_CYCLES(2)
  ) dut (
    .clock             (clock),
    .resetActiveLow    (resetActiveLow),
    .instructionValid  (instructionValid),
    .pcCurrent         (pcCurrent),
    .illegalInstruction(illegalInstruction),
    .ecallDetected     (ecallDetected),
    .ebreakDetected    (ebreakDetected),
    .mretDetected      (mretDetected),
    .externalIrq       (externalIrq),
    .timerIrq          (timerIrq),
    .mepcValue         (mepcValue),
    .csrWriteEnable    (csrWriteEnable),
    .mepcWriteValue    (mepcWriteValue),
    .mcauseValue       (mcauseValue),
    .pcRedirectValid   (pcRedirectValid),
    .pcRedirectTarget  (pcRedirectTarget),
    .pipelineStall     (pipelineStall),
    .pipelineFlush     (pipelineFlush),
    .inTrapHandler     (inTrapHandler)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic        ill, ec, eb, mr, ext, tmr;
    logic [31:0] mepc;
    logic        we;
    logic [31:0] mw, mc;
    logic        rv;
    logic [31:0] rt;
    logic        st, fl, ih;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] CE = 32'h8000_000B;
  localparam logic [31:0] CT = 32'h8000_0007;

  function automatic logic [100:0] packExp(input logic we, input logic [31:0] mw, input logic [31:0] mc,
                                           input logic rv, input logic [31:0] rt,
                                           input logic st, input logic fl, input logic ih);
    return {we, mw, mc, rv, rt, st, fl, ih};
  endfunction

  task automatic check(input string name, input logic [100:0] exp);
    logic [100:0] act;
    act = {csrWriteEnable, mepcWriteValue, mcauseValue, pcRedirectValid, pcRedirectTarget,
           pipelineStall, pipelineFlush, inTrapHandler};
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got we=%0b mepcw=%h mcause=%h rv=%0b rt=%h st=%0b fl=%0b ih=%0b, want %h (got %h)",
               name, act[100], act[99:68], act[67:36], act[35], act[34:3], act[2], act[1], act[0],
               exp, act);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] pc, input logic ill, input logic ec,
                       input logic eb, input logic mr, input logic ext, input logic tmr,
                       input logic [31:0] mepc);
    instructionValid   = iv;
    pcCurrent          = pc;
    illegalInstruction = ill;
    ecallDetected      = ec;
    ebreakDetected     = eb;
    mretDetected       = mr;
    externalIrq        = ext;
    timerIrq           = tmr;
    mepcValue          = mepc;
  endtask

  task automatic row(input logic iv, input logic [31:0] pc, input logic ill, input logic ec,
                     input logic eb, input logic mr, input logic ext, input logic tmr,
                     input logic [31:0] mepc, input logic we, input logic [31:0] mw,
                     input logic [31:0] mc, input logic rv, input logic [31:0] rt,
                     input logic st, input logic fl, input logic ih);
    vecs.push_back('{iv, pc, ill, ec, eb, mr, ext, tmr, mepc, we, mw, mc, rv, rt, st, fl, ih});
  endtask

  initial begin
    // ecall trap, masked timer in handler, mret to 0x44, pending timer taken in IDLE
    row(1, 32'h40, 0,1,0,0,0,0, 32'h0,   1, 32'h40, 32'd11, 0, 32'h0,   1,0,0);
    row(0, 32'h0,  0,0,0,0,0,0, 32'h0,   0, 32'h40, 32'd11, 1, 32'h100, 1,1,0);
    row(0, 32'h0,  0,0,0,0,0,0, 32'h0,   0, 32'h40, 32'd11, 0, 32'h0,   0,1,1);
    row(0, 32'h0,  0,0,0,0,0,0, 32'h0,   0, 32'h40, 32'd11, 0, 32'h0,   0,1,1);
    row(0, 32'h0,  0,0,0,0,0,0, 32'h0,   0, 32'h40, 32'd11, 0, 32'h0,   0,0,1);
    row(1, 32'h50, 0,0,0,0,0,1, 32'h0,   0, 32'h40, 32'd11, 0, 32'h0,   0,0,1);
    row(1, 32'h54, 0,0,0,1,0,1, 32'h44,  0, 32'h40, 32'd11, 1, 32'h44,  1,1,1);
    row(1, 32'h58, 0,0,0,0,0,1, 32'h44,  0, 32'h40, 32'd11, 0, 32'h0,   0,1,0);
    row(0, 32'h0,  0,0,0,0,0,1, 32'h44,  0, 32'h40, 32'd11, 0, 32'h0,   0,1,0);
    row(0, 32'h0,  0,0,0,0,0,1, 32'h44,  0, 32'h40, 32'd11, 0, 32'h0,   0,0,0);
    row(0, 32'h0,  0,0,0,0,0,1, 32'h44,  0, 32'h40, 32'd11, 0, 32'h0,   0,0,0);
    row(1, 32'h48, 0,0,0,0,0,1, 32'h44,  1, 32'h48, CT,     0, 32'h0,   1,0,0);
    // events during REDIRECT/FLUSH ignored, then nested illegal beats mret in HANDLER
    row(1, 32'h99, 1,1,0,0,1,0, 32'h44,  0, 32'h48, CT,     1, 32'h100, 1,1,0);
    row(1, 32'h9c, 1,0,0,0,0,0, 32'h44,  0, 32'h48, CT,     0, 32'h0,   0,1,1);
    row(1, 32'ha0, 1,0,0,0,0,0, 32'h44,  0, 32'h48, CT,     0, 32'h0,   0,1,1);
    row(1, 32'ha4, 1,0,0,0,0,0, 32'h44,  0, 32'h48, CT,     0, 32'h0,   0,0,1);
    row(1, 32'h104,1,0,0,1,0,0, 32'h44,  1, 32'h104,32'd2,  0, 32'h0,   1,0,0);
    row(0, 32'h0,  0,0,0,0,0,0, 32'h44,  0, 32'h104,32'd2,  1, 32'h100, 1,1,0);
    row(0, 32'h0,  0,0,0,0,0,0, 32'h44,  0, 32'h104,32'd2,  0, 32'h0,   0,1,1);
    row(0, 32'h0,  0,0,0,0,0,0, 32'h44,  0, 32'h104,32'd2,  0, 32'h0,   0,1,1);
    row(0, 32'h0,  0,0,0,0,0,0, 32'h44,  0, 32'h104,32'd2,  0, 32'h0,   0,0,1);
    row(1, 32'h108,0,0,0,1,0,0, 32'h200, 0, 32'h104,32'd2,  1, 32'h200, 1,1,1);
    row(0, 32'h0,  0,0,0,0,0,0, 32'h200, 0, 32'h104,32'd2,  0, 32'h0,   0,1,0);
    row(0, 32'h0,  0,0,0,0,0,0, 32'h200, 0, 32'h104,32'd2,  0, 32'h0,   0,1,0);
    row(0, 32'h0,  0,0,0,0,0,0, 32'h200, 0, 32'h104,32'd2,  0, 32'h0,   0,0,0);
    // mret outside the handler is an illegal-instruction trap
    row(1, 32'h20, 0,0,0,1,0,0, 32'h200, 1, 32'h20, 32'd2,  0, 32'h0,   1,0,0);
    row(0, 32'h0,  0,0,0,0,0,0, 32'h200, 0, 32'h20, 32'd2,  1, 32'h100, 1,1,0);
    row(0, 32'h0,  0,0,0,0,0,0, 32'h200, 0, 32'h20, 32'd2,  0, 32'h0,   0,1,1);
    row(0, 32'h0,  0,0,0,0,0,0, 32'h200, 0, 32'h20, 32'd2,  0, 32'h0,   0,1,1);
    row(0, 32'h0,  0,0,0,0,0,0, 32'h200, 0, 32'h20, 32'd2,  0, 32'h0,   0,0,1);
    row(1, 32'h10c,0,0,1,0,0,0, 32'h200, 1, 32'h10c,32'd3,  0, 32'h0,   1,0,0);
    row(0, 32'h0,  0,0,0,0,0,0, 32'h200, 0, 32'h10c,32'd3,  1, 32'h100, 1,1,0);

    resetActiveLow = 1'b0;
    drive(0, 32'h0, 0,0,0,0,0,0, 32'h0);
    #1;
    check("reset_state", '0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetActiveLow = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].pc, vecs[i].ill, vecs[i].ec, vecs[i].eb, vecs[i].mr,
            vecs[i].ext, vecs[i].tmr, vecs[i].mepc);
      @(posedge clock);
      #1;
      check($sformatf("vec%0d", i), packExp(vecs[i].we, vecs[i].mw, vecs[i].mc, vecs[i].rv,
                                             vecs[i].rt, vecs[i].st, vecs[i].fl, vecs[i].ih));
    end

    // Asynchronous reset while in REDIRECT with the external irq held high
    drive(1, 32'h80, 0,0,0,0,1,0, 32'h0);
    #1 resetActiveLow = 1'b0;
    #1 check("async_reset_redirect", '0);
    @(posedge clock);
    #1 check("held_in_reset", '0);
    @(negedge clock);
    resetActiveLow = 1'b1;
    drive(0, 32'h80, 0,0,0,0,1,0, 32'h0);
    @(posedge clock);
    #1 check("after_release_irq_not_valid", '0);
    drive(1, 32'h80, 1,1,0,0,1,0, 32'h0);
    @(posedge clock);
    #1 check("ext_beats_illegal_ecall", packExp(1, 32'h80, CE, 0, 32'h0, 1, 0, 0));
    drive(0, 32'h0, 0,0,0,0,0,0, 32'h0);
    @(posedge clock);
    #1 check("ext_redirect", packExp(0, 32'h80, CE, 1, 32'h100, 1, 1, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Machine-mode trap sequencer for the single-hart core.
- Detects synchronous exceptions (illegal, ecall, ebreak) and interrupts (external, timer), and picks one by fixed priority.
- Sequences the trap: commands the mepc CSR write, produces mcause, redirects the PC to the trap vector and flushes the pipeline.
- Also sequences mret back to the saved mepc, and masks interrupts while the handler runs.

Parameters:
- TRAP_VECTOR, 32'h0000_0100, handler entry address driven on pcRedirectTarget when a trap is taken.
- FLUSH_CYCLES, 2, number of flush cycles after each redirect; legal range 1..15.

Ports:
- clock  in  1  system clock
- resetActiveLow  in  1  async active-low reset
- instructionValid  in  1  instruction at pcCurrent is valid; qualifies all events
- pcCurrent  in  32  PC of instruction in decode
- illegalInstruction  in  1  illegal opcode detected
- ecallDetected  in  1  ECALL decoded
- ebreakDetected  in  1  EBREAK decoded
- mretDetected  in  1  MRET decoded
- externalIrq  in  1  level external interrupt
- timerIrq  in  1  level timer interrupt
- mepcValue  in  32  current mepc from CSR unit
- csrWriteEnable  out  1  one-cycle mepc write strobe
- mepcWriteValue  out  32  PC to save; connects to CSR unit pcFromCore
- mcauseValue  out  32  registered cause of last trap
- pcRedirectValid  out  1  one-cycle PC override strobe
- pcRedirectTarget  out  32  redirect address
- pipelineStall  out  1  freeze fetch/decode
- pipelineFlush  out  1  squash in-flight instructions
- inTrapHandler  out  1  handler active; interrupts masked

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0, including mcauseValue, mepcWriteValue and pcRedirectTarget.
- States: IDLE, CAPTURE, REDIRECT, FLUSH, HANDLER, RETURN.
- Event sampling: only in IDLE and HANDLER, and only when instructionValid=1. In all other states inputs are ignored.
- Priority, highest first, with cause values:
  - externalIrq: 0x8000000B
  - timerIrq: 0x80000007
  - illegalInstruction: 2
  - ebreakDetected: 3
  - ecallDetected: 11
  - mret outside handler: 2
- IDLE:
  - Any event → CAPTURE. Latch pcCurrent into mepcWriteValue and the cause into mcauseValue that same edge.
  - mretDetected with no other event is treated as illegal (cause 2).
- CAPTURE (1 cycle): csrWriteEnable=1, pipelineStall=1. → REDIRECT.
- REDIRECT (1 cycle): pcRedirectValid=1, pcRedirectTarget=TRAP_VECTOR, pipelineFlush=1, pipelineStall=1. → FLUSH; the 4-bit counter loads FLUSH_CYCLES-1.
- FLUSH:
  - pipelineFlush=1, pipelineStall=0.
  - The counter decrements each cycle. At 0 → HANDLER if the sequence was a trap, → IDLE if it was a return.
  - A 1-bit return flag records which.
- HANDLER:
  - inTrapHandler=1. Interrupts are ignored (masked).
  - Synchronous exception → CAPTURE. Nested trap; mepc and mcause are overwritten.
  - mretDetected (no exception) → RETURN.
  - An exception and mret in the same cycle: the exception wins.
- RETURN (1 cycle):
  - pcRedirectValid=1, pcRedirectTarget=mepcValue sampled this cycle, pipelineFlush=1, pipelineStall=1.
  - Set the return flag. → FLUSH.
- inTrapHandler is 1 in HANDLER and RETURN, and through FLUSH following a trap redirect.
- Latency: event edge → csrWriteEnable next cycle → pcRedirectValid the cycle after. Trap entry = 2 cycles plus FLUSH_CYCLES.
- mepcWriteValue and mcauseValue hold until the next trap.
- Interrupt lines are level. An irq still high on return to IDLE is taken on the next valid instruction.

Test Plan:
- Reset mid-REDIRECT, with irq held high during reset → the cycle after release all outputs are 0 and state=IDLE; the irq is taken only on a later valid instruction.
- ecall at pc=0x40, instructionValid=1 → csrWriteEnable=1 with mepcWriteValue=0x40 next cycle; then pcRedirectValid=1 target 0x100; flush 2 cycles; mcauseValue=11; inTrapHandler=1.
- externalIrq+illegal+ecall together at pc=0x80 → mcauseValue=0x8000000B, mepcWriteValue=0x80.
- In HANDLER: timerIrq=1 → ignored; then mret with mepcValue=0x44 → redirect to 0x44, flush 2 cycles, IDLE, inTrapHandler=0; timer trap is then taken at the next valid pc.
- mret in IDLE at pc=0x20 → trap with mcauseValue=2, mepcWriteValue=0x20.
- Illegal in HANDLER at pc=0x104 → nested trap; mepcWriteValue=0x104, mcauseValue=2, redirect to 0x100 again. Events asserted during CAPTURE/FLUSH are ignored.
